// File: rtl/apb_pkg.sv
// Shared APB master definitions: FSM states, CONTROL bit positions and the
// LSU-visible register map.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ERR    = 2'd3
  } apb_state_e;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_WRITE_BIT = 1;

  localparam logic [15:0] APB_PADDR_ADDR   = 16'h7900;
  localparam logic [15:0] APB_PWDATA_ADDR  = 16'h7904;
  localparam logic [15:0] APB_SEL_ADDR     = 16'h7908;
  localparam logic [15:0] APB_CONTROL_ADDR = 16'h790C;

endpackage

// File: rtl/apb_slave_mux.sv
// Return-path mux: picks PRDATA/PREADY/PSLVERR of the selected slave.
// An out-of-range select yields an all-zero triple.
module apb_slave_mux #(
  parameter int DATA_W = 32,
  parameter int NSLV   = 4
) (
  input  logic [1:0]             i_sel,
  input  logic [NSLV*DATA_W-1:0] i_prdata,
  input  logic [NSLV-1:0]        i_pready,
  input  logic [NSLV-1:0]        i_pslverr,
  output logic [DATA_W-1:0]      o_rdata,
  output logic                   o_ready,
  output logic                   o_slverr
);

  always_comb begin
    o_rdata  = '0;
    o_ready  = 1'b0;
    o_slverr = 1'b0;
    for (int k = 0; k < NSLV; k++) begin
      if (int'(i_sel) == k) begin
        o_rdata  = i_prdata[k*DATA_W +: DATA_W];
        o_ready  = i_pready[k];
        o_slverr = i_pslverr[k];
      end
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master sequencer: one SETUP/ACCESS transfer per CONTROL start edge.
// Define APB_TIMEOUT_EN to compile in the ACCESS-phase timeout abort.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int NSLV    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [ADDR_W-1:0]      i_apb_paddr_reg,
  input  logic [DATA_W-1:0]      i_apb_pwdata_reg,
  input  logic [1:0]             i_apb_sel_reg,
  input  logic [1:0]             i_apb_control_reg,
  output logic [ADDR_W-1:0]      o_paddr,
  output logic [DATA_W-1:0]      o_pwdata,
  output logic                   o_pwrite,
  output logic [NSLV-1:0]        o_psel,
  output logic                   o_penable,
  input  logic [NSLV*DATA_W-1:0] i_prdata,
  input  logic [NSLV-1:0]        i_pready,
  input  logic [NSLV-1:0]        i_pslverr,
  output logic [DATA_W-1:0]      o_rdata,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);

  apb_state_e        state_q, state_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              write_q, write_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              start;
  logic              sel_bad;
  logic              timeout;
  logic [DATA_W-1:0] mux_rdata;
  logic              mux_ready;
  logic              mux_slverr;

  apb_slave_mux #(
    .DATA_W (DATA_W),
    .NSLV   (NSLV)
  ) u_mux (
    .i_sel     (sel_q),
    .i_prdata  (i_prdata),
    .i_pready  (i_pready),
    .i_pslverr (i_pslverr),
    .o_rdata   (mux_rdata),
    .o_ready   (mux_ready),
    .o_slverr  (mux_slverr)
  );

  assign start   = i_apb_control_reg[CTRL_EN_BIT] & ~en_q;
  assign sel_bad = int'(i_apb_sel_reg) >= NSLV;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout = (cnt_q == CNT_MAX);

  // Cleared on the way into ACCESS; saturates by aborting at CNT_MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_SETUP)
      cnt_d = '0;
    else if (state_q == ST_ACCESS && !mux_ready && !timeout)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    en_d     = i_apb_control_reg[CTRL_EN_BIT];
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    write_d  = write_q;
    sel_d    = sel_q;
    rdata_d  = rdata_q;
    done_d   = done_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          paddr_d  = i_apb_paddr_reg;
          pwdata_d = i_apb_pwdata_reg;
          write_d  = i_apb_control_reg[CTRL_WRITE_BIT];
          sel_d    = i_apb_sel_reg;
          done_d   = 1'b0;
          err_d    = 1'b0;
          state_d  = sel_bad ? ST_ERR : ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        // A ready slave wins over a coincident timeout.
        if (mux_ready) begin
          if (!write_q) rdata_d = mux_rdata;
          err_d   = mux_slverr;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      write_q  <= 1'b0;
      sel_q    <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      write_q  <= write_d;
      sel_q    <= sel_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Bus strobes decode straight from state so reset drops them at once.
  always_comb begin
    o_psel = '0;
    if (state_q == ST_SETUP || state_q == ST_ACCESS) begin
      for (int k = 0; k < NSLV; k++)
        o_psel[k] = (int'(sel_q) == k);
    end
  end

  assign o_penable = (state_q == ST_ACCESS);
  assign o_busy    = (state_q != ST_IDLE);
  assign o_paddr   = paddr_q;
  assign o_pwdata  = pwdata_q;
  assign o_pwrite  = write_q;
  assign o_rdata   = rdata_q;
  assign o_done    = done_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: directed scenarios plus a
// randomized run compared every cycle against a transfer-level model.
module tb_apb_master_ctrl;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int NS  = 3;
  localparam int TO  = 16;

  logic              clk;
  logic              rst;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [1:0]        sel;
  logic [1:0]        ctrl;
  logic [NS*DW-1:0]  prdata;
  logic [NS-1:0]     pready;
  logic [NS-1:0]     pslverr;

  logic [AW-1:0]     o_paddr;
  logic [DW-1:0]     o_pwdata;
  logic              o_pwrite;
  logic [NS-1:0]     o_psel;
  logic              o_penable;
  logic [DW-1:0]     o_rdata;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  int errors = 0;
  int checks = 0;
  bit run = 0;

  apb_master_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .NSLV   (NS),
    .TIMEOUT(TO)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_apb_paddr_reg   (paddr),
    .i_apb_pwdata_reg  (pwdata),
    .i_apb_sel_reg     (sel),
    .i_apb_control_reg (ctrl),
    .o_paddr           (o_paddr),
    .o_pwdata          (o_pwdata),
    .o_pwrite          (o_pwrite),
    .o_psel            (o_psel),
    .o_penable         (o_penable),
    .i_prdata          (prdata),
    .i_pready          (pready),
    .i_pslverr         (pslverr),
    .o_rdata           (o_rdata),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_err             (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Transfer-level model: "age" counts cycles since the start was accepted
  // (0 = address phase, >=1 = access phase cycle age-1).
  bit            m_active;
  bit            m_bad;
  int            m_age;
  bit            m_prev;
  logic [1:0]    m_sel;
  bit            m_wr;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata;
  logic [DW-1:0] m_rdata;
  bit            m_done;
  bit            m_err;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 0; m_bad <= 0; m_age <= 0; m_prev <= 0;
      m_sel <= 0; m_wr <= 0; m_paddr <= 0; m_pwdata <= 0;
      m_rdata <= 0; m_done <= 0; m_err <= 0;
    end else begin
      m_prev <= ctrl[0];
      if (m_active) begin
        if (m_bad) begin
          m_active <= 0; m_done <= 1; m_err <= 1;
        end else if (m_age == 0) begin
          m_age <= 1;
        end else if (pready[m_sel]) begin
          m_active <= 0;
          m_done   <= 1;
          m_err    <= pslverr[m_sel];
          if (!m_wr) m_rdata <= prdata[m_sel*DW +: DW];
        end
`ifdef APB_TIMEOUT_EN
        else if (m_age - 1 == TO - 1) begin
          m_active <= 0; m_done <= 1; m_err <= 1;
        end
`endif
        else begin
          m_age <= m_age + 1;
        end
      end else if (ctrl[0] && !m_prev) begin
        m_active <= 1;
        m_bad    <= int'(sel) >= NS;
        m_age    <= 0;
        m_sel    <= sel;
        m_wr     <= ctrl[1];
        m_paddr  <= paddr;
        m_pwdata <= pwdata;
        m_done   <= 0;
        m_err    <= 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [NS-1:0] e_psel;
    logic          e_pen;
    if (run) begin
      e_psel = (m_active && !m_bad) ? NS'(1 << m_sel) : '0;
      e_pen  = m_active && !m_bad && (m_age >= 1);
      chk("m_psel",   32'(o_psel),    32'(e_psel));
      chk("m_penable", 32'(o_penable), 32'(e_pen));
      chk("m_busy",   32'(o_busy),    32'(m_active));
      chk("m_done",   32'(o_done),    32'(m_done));
      chk("m_err",    32'(o_err),     32'(m_err));
      chk("m_rdata",  o_rdata,        m_rdata);
      chk("m_paddr",  32'(o_paddr),   32'(m_paddr));
      chk("m_pwdata", o_pwdata,       m_pwdata);
      chk("m_pwrite", 32'(o_pwrite),  32'(m_wr));
    end
  end

  initial begin
    logic [DW-1:0] r0;
    int busy_cnt;
    rst = 0; ctrl = 0; paddr = 0; pwdata = 0; sel = 0;
    prdata = '0; pready = '0; pslverr = '0;
    repeat (3) step();
    chk("rst_psel",  32'(o_psel),  0);
    chk("rst_busy",  32'(o_busy),  0);
    chk("rst_done",  32'(o_done),  0);
    chk("rst_rdata", o_rdata,      0);
    #3 rst = 1;
    run = 1;
    step();

    // Write, zero wait
    paddr = 5'h04; pwdata = 32'hDEADBEEF; sel = 1; ctrl = 2'b11;
    pready = '1; pslverr = '0;
    r0 = o_rdata;
    step();
    chk("wr_setup_psel", 32'(o_psel), 32'h2);
    chk("wr_setup_pen",  32'(o_penable), 0);
    step();
    chk("wr_acc_pen",    32'(o_penable), 1);
    chk("wr_acc_paddr",  32'(o_paddr), 32'h04);
    chk("wr_acc_pwdata", o_pwdata, 32'hDEADBEEF);
    chk("wr_acc_pwrite", 32'(o_pwrite), 1);
    step();
    chk("wr_done",  32'(o_done), 1);
    chk("wr_err",   32'(o_err), 0);
    chk("wr_rdata", o_rdata, r0);
    ctrl = 0; step();

    // Read with three wait states
    sel = 0; pready = '0; prdata = '0; ctrl = 2'b01;
    for (int j = 1; j <= 6; j++) begin
      step();
      if (j <= 5) chk("rd3_busy", 32'(o_busy), 1);
      if (j == 5) begin pready[0] = 1'b1; prdata[31:0] = 32'h41; end
      if (j == 6) begin
        chk("rd3_rdata", o_rdata, 32'h41);
        chk("rd3_done",  32'(o_done), 1);
        chk("rd3_idle",  32'(o_busy), 0);
      end
    end
    ctrl = 0; step();

    // PSLVERR on slave 2
    sel = 2; pready = 3'b100; pslverr = 3'b100;
    prdata[64 +: 32] = 32'h1234_5678; ctrl = 2'b01;
    repeat (3) step();
    chk("slverr_done",  32'(o_done), 1);
    chk("slverr_err",   32'(o_err), 1);
    chk("slverr_rdata", o_rdata, 32'h1234_5678);
    ctrl = 0; pslverr = '0; step();

    // Select beyond NSLV goes straight to the error cycle
    sel = 3; ctrl = 2'b01;
    step();
    chk("bad_busy", 32'(o_busy), 1);
    chk("bad_psel", 32'(o_psel), 0);
    step();
    chk("bad_done", 32'(o_done), 1);
    chk("bad_err",  32'(o_err), 1);
    ctrl = 0; step();

    // Held enable level starts exactly one transfer
    sel = 1; pready = '1; ctrl = 2'b01; busy_cnt = 0;
    repeat (10) begin
      step();
      if (o_busy) busy_cnt++;
    end
    chk("hold_one_xfer", 32'(busy_cnt), 2);
    ctrl = 0; step();

    // Snapshot protection and ignored start during ACCESS
    sel = 1; paddr = 5'h0A; pready = '0; ctrl = 2'b11;
    step(); step();
    ctrl = 0; paddr = 5'h1F;
    step();
    chk("snap_paddr_a", 32'(o_paddr), 32'h0A);
    ctrl = 2'b11;
    step();
    chk("snap_paddr_b", 32'(o_paddr), 32'h0A);
    pready = '1;
    step();
    chk("snap_done", 32'(o_done), 1);
    step();
    chk("no_queue_a", 32'(o_busy), 0);
    step();
    chk("no_queue_b", 32'(o_busy), 0);
    ctrl = 0; step();

`ifdef APB_TIMEOUT_EN
    sel = 0; pready = '0; ctrl = 2'b01;
    for (int j = 1; j <= 18; j++) begin
      step();
      if (j == 17) chk("to_last_acc", 32'(o_penable), 1);
      if (j == 18) begin
        chk("to_psel", 32'(o_psel), 0);
        chk("to_done", 32'(o_done), 1);
        chk("to_err",  32'(o_err), 1);
      end
    end
    ctrl = 0; step();
`endif

    // Reset mid-ACCESS
    sel = 0; pready = '0; ctrl = 2'b01;
    step(); step();
    #3 rst = 0;
    #1;
    chk("rst_mid_psel", 32'(o_psel), 0);
    chk("rst_mid_pen",  32'(o_penable), 0);
    chk("rst_mid_done", 32'(o_done), 0);
    ctrl = 0;
    step();
    #3 rst = 1;
    step();
    sel = 2; pready = '1; ctrl = 2'b01;
    repeat (3) step();
    chk("post_rst_done", 32'(o_done), 1);
    ctrl = 0; step();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 3) == 0) ctrl[0] = ~ctrl[0];
      ctrl[1] = 1'($urandom);
      paddr   = AW'($urandom);
      pwdata  = $urandom;
      sel     = 2'($urandom);
      pready  = NS'($urandom);
      pslverr = NS'($urandom);
      prdata  = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 699) == 0) begin
        #3 rst = 0;
        step();
        #3 rst = 1;
      end
    end

    step();
    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
